// File: rtl/pr_frame_pkg.sv
// Shared types and constants for the framed serial parity checker.
package pr_frame_pkg;

  // Per-channel frame phase: collecting data bits, or expecting the parity bit.
  typedef enum logic {
    PR_DATA = 1'b0,
    PR_PAR  = 1'b1
  } pr_st_t;

  // Parity mode encodings as seen on the mode input.
  localparam logic PR_EVEN = 1'b0;
  localparam logic PR_ODD  = 1'b1;

endpackage

// File: rtl/pr_frame_chan.sv
// One serial channel: running parity over DATA_W data bits, parity-bit check against the
// mode latched at the first data bit, a one-cycle done/error pulse and a saturating error count.
module pr_frame_chan
  import pr_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             mode,
  input  logic             sr_in,
  input  logic             sr_vld,
  output logic             par_out,
  output logic             frm_done,
  output logic             frm_err,
  output logic [CNT_W-1:0] err_cnt
);

  // A 1-bit index still works when DATA_W is 1 (index stays 0).
  localparam int unsigned     IdxW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  pr_st_t           st_q;
  logic [IdxW-1:0]  idx_q;
  logic             par_q;
  logic             mode_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             chk_err;

  // Mismatch between accumulated parity, received parity bit and the frame's mode.
  assign chk_err = par_q ^ sr_in ^ mode_q;

  // Channel FSM with registered done/error pulse and saturating counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= PR_DATA;
      idx_q  <= '0;
      par_q  <= 1'b0;
      mode_q <= PR_EVEN;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (clr) begin
        // Partial frame is dropped; the bit offered this cycle is discarded.
        st_q   <= PR_DATA;
        idx_q  <= '0;
        par_q  <= 1'b0;
        mode_q <= PR_EVEN;
        cnt_q  <= '0;
      end else if (sr_vld) begin
        unique case (st_q)
          PR_DATA: begin
            par_q <= par_q ^ sr_in;
            if (idx_q == '0) begin
              mode_q <= mode;
            end
            if (idx_q == LastIdx) begin
              idx_q <= '0;
              st_q  <= PR_PAR;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          PR_PAR: begin
            done_q <= 1'b1;
            err_q  <= chk_err;
            if (chk_err && (cnt_q != CntMax)) begin
              cnt_q <= cnt_q + 1'b1;
            end
            par_q <= 1'b0;
            idx_q <= '0;
            st_q  <= PR_DATA;
          end
          default: st_q <= PR_DATA;
        endcase
      end
    end
  end

  assign par_out  = par_q;
  assign frm_done = done_q;
  assign frm_err  = err_q;
  assign err_cnt  = cnt_q;

endmodule

// File: rtl/pr_frame_checker.sv
// Multi-channel framed serial parity checker: NCH independent channels plus port packing.
module pr_frame_checker
  import pr_frame_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 mode,
  input  logic [NCH-1:0]       sr_in,
  input  logic [NCH-1:0]       sr_vld,
  output logic [NCH-1:0]       par_out,
  output logic [NCH-1:0]       frm_done,
  output logic [NCH-1:0]       frm_err,
  output logic [NCH*CNT_W-1:0] err_cnt
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pr_frame_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .mode     (mode),
      .sr_in    (sr_in[i]),
      .sr_vld   (sr_vld[i]),
      .par_out  (par_out[i]),
      .frm_done (frm_done[i]),
      .frm_err  (frm_err[i]),
      .err_cnt  (err_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pr_frame_checker.sv
// Scoreboard bench for pr_frame_checker (NCH=4, DATA_W=8, CNT_W=2).
module tb_pr_frame_checker;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 2;

  logic           clk    = 1'b0;
  logic           rst    = 1'b0;
  logic           clr    = 1'b0;
  logic           mode   = 1'b0;
  logic [NCH-1:0] sr_in  = '0;
  logic [NCH-1:0] sr_vld = '0;
  logic [NCH-1:0] par_out;
  logic [NCH-1:0] frm_done;
  logic [NCH-1:0] frm_err;
  logic [NCH*CW-1:0] err_cnt;

  always #5 clk = ~clk;

  pr_frame_checker #(
    .NCH    (NCH),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .mode     (mode),
    .sr_in    (sr_in),
    .sr_vld   (sr_vld),
    .par_out  (par_out),
    .frm_done (frm_done),
    .frm_err  (frm_err),
    .err_cnt  (err_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Expected frm_err per completed frame, per channel (hand-computed at push time).
  logic exp_q[NCH][$];
  int   exp_cnt[NCH];
  logic [NCH-1:0] exp_par = '0;
  int   zero_gen  = 0;
  int   zero_seen = 0;
  bit   end_req   = 1'b0;
  bit   end_done  = 1'b0;

  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s ch%0d @%0t: got %0h, expected %0h", name, c, $time, act, exp_v);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (zero_gen != zero_seen) begin
      for (int c = 0; c < NCH; c++) exp_cnt[c] = 0;
      zero_seen = zero_gen;
    end
    if (!rst) begin
      chk("reset_par_out", -1, 32'(par_out), 32'd0);
      chk("reset_frm_done", -1, 32'(frm_done), 32'd0);
      chk("reset_frm_err", -1, 32'(frm_err), 32'd0);
      chk("reset_err_cnt", -1, 32'(err_cnt), 32'd0);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        chk("par_out", c, 32'(par_out[c]), 32'(exp_par[c]));
        if (frm_done[c]) begin
          if (exp_q[c].size() == 0) begin
            chk("unexpected_done", c, 32'(frm_done[c]), 32'd0);
          end else begin
            logic e;
            e = exp_q[c].pop_front();
            if (e && exp_cnt[c] < 3) exp_cnt[c]++;
            chk("frm_err", c, 32'(frm_err[c]), 32'(e));
          end
        end else begin
          chk("err_without_done", c, 32'(frm_err[c]), 32'd0);
        end
        chk("err_cnt", c, 32'(err_cnt[c*CW +: CW]), 32'(exp_cnt[c]));
      end
    end
    if (end_req && !end_done) begin
      for (int c = 0; c < NCH; c++) chk("missing_done", c, 32'(exp_q[c].size()), 32'd0);
      end_done = 1'b1;
    end
  end

  function automatic logic [8:0] f(input logic [7:0] d, input logic p);
    return {d, p};
  endfunction

  task automatic expect_frame(input int c, input logic e);
    exp_q[c].push_back(e);
  endtask

  task automatic idle(input int n);
    sr_vld = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends nbits of each masked channel's {data[7:0], parity} MSB first; mode m0 for bits 0-3,
  // m1 afterwards. gap<0 inserts 1..5 idle cycles between bits, gap>0 a fixed count.
  task automatic send(input logic [3:0] mask, input logic [35:0] frm, input logic m0,
                      input logic m1, input int gap, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      mode   = (b < 4) ? m0 : m1;
      sr_vld = mask;
      for (int c = 0; c < NCH; c++) sr_in[c] = frm[c*9 + 8 - b];
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) exp_par[c] = (b == 8) ? 1'b0 : (exp_par[c] ^ sr_in[c]);
      end
      if (gap != 0 && b < nbits - 1) begin
        sr_vld = '0;
        sr_in  = ~sr_in;
        repeat ((gap < 0) ? (b % 5) + 1 : gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Synchronous clear offered together with valid ones on every channel.
  task automatic do_clr();
    clr    = 1'b1;
    sr_vld = '1;
    sr_in  = '1;
    @(posedge clk);
    #1;
    clr     = 1'b0;
    sr_vld  = '0;
    exp_par = '0;
    zero_gen++;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // 8'hB1 has 4 ones.
    expect_frame(0, 1'b0); send(4'b0001, {27'd0, f(8'hB1, 1'b0)}, 1'b0, 1'b0, 0, 9); idle(2);
    expect_frame(0, 1'b1); send(4'b0001, {27'd0, f(8'hB1, 1'b1)}, 1'b0, 1'b0, 0, 9); idle(2);
    expect_frame(0, 1'b0); send(4'b0001, {27'd0, f(8'hB1, 1'b1)}, 1'b1, 1'b1, 0, 9); idle(2);
    // Same errored frame with 1-5 cycle gaps between bits.
    expect_frame(0, 1'b1); send(4'b0001, {27'd0, f(8'hB1, 1'b1)}, 1'b0, 1'b0, -1, 9); idle(2);
    // Mode flips to odd after bit 3: still checked even. Next frame odd.
    expect_frame(0, 1'b0); send(4'b0001, {27'd0, f(8'hB1, 1'b0)}, 1'b0, 1'b1, 0, 9); idle(1);
    expect_frame(0, 1'b1); send(4'b0001, {27'd0, f(8'hB1, 1'b0)}, 1'b1, 1'b1, 0, 9); idle(2);

    do_clr();
    idle(2);

    // Five errored frames back-to-back on ch1: count saturates at 3.
    for (int k = 0; k < 5; k++) begin
      expect_frame(1, 1'b1);
      send(4'b0010, {18'd0, f(8'h01, 1'b0), 9'd0}, 1'b0, 1'b0, 0, 9);
    end
    idle(2);

    // All channels concurrently, even mode.
    expect_frame(0, 1'b0);
    expect_frame(1, 1'b0);
    expect_frame(2, 1'b1);
    expect_frame(3, 1'b1);
    send(4'hF, {f(8'h00, 1'b1), f(8'h07, 1'b0), f(8'h07, 1'b1), f(8'hFF, 1'b0)},
         1'b0, 1'b0, 2, 9);
    idle(2);

    // Clear after five bits of a frame, then a full frame must align.
    send(4'b0001, {27'd0, f(8'hE0, 1'b0)}, 1'b0, 1'b0, 0, 5);
    do_clr();
    idle(2);
    expect_frame(0, 1'b1); send(4'b0001, {27'd0, f(8'h03, 1'b1)}, 1'b0, 1'b0, 0, 9); idle(2);

    // Asynchronous reset mid-frame.
    send(4'b0001, {27'd0, f(8'hE0, 1'b0)}, 1'b0, 1'b0, 0, 3);
    sr_vld  = '0;
    rst     = 1'b0;
    exp_par = '0;
    zero_gen++;
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    expect_frame(2, 1'b1); send(4'b0100, {9'd0, f(8'hFF, 1'b0), 18'd0}, 1'b1, 1'b1, 0, 9);
    idle(3);

    end_req = 1'b1;
    wait (end_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
